// File: rtl/tick_pkg.sv
// ---------------------------------------------------------------------------
// tick_pkg
//   Shared definitions for the CPU tick controller.
//   - mode_e      : CPU stepping mode encodings (HALT, STEP, RUN, FREE)
//   - reload_calc : divider reload value for a board clock / tick rate pair
// ---------------------------------------------------------------------------
package tick_pkg;

  typedef enum logic [1:0] {
    MODE_HALT = 2'b00,
    MODE_STEP = 2'b01,
    MODE_RUN  = 2'b10,
    MODE_FREE = 2'b11
  } mode_e;

  // A divider reloaded with R expires once every R+1 cycles, hence the -1.
  function automatic int unsigned reload_calc(input int unsigned clk_hz,
                                              input int unsigned tick_hz);
    return (clk_hz / tick_hz) - 1;
  endfunction

endpackage

// File: rtl/step_debounce.sv
// ---------------------------------------------------------------------------
// step_debounce
//   Turns the raw, asynchronous step push button into a single-cycle request.
//   A 2-flop synchroniser feeds a stability counter; the debounced level only
//   changes once the synchronised input has differed from it for
//   DEBOUNCE_CYCLES consecutive cycles. An accepted rising transition emits a
//   one-cycle registered pulse; releases and short glitches emit nothing.
//
// Ports:
//   clk     in  : board clock
//   resetn  in  : asynchronous active-low reset
//   btn     in  : raw push button, active-high
//   pulse   out : one-cycle pulse per accepted press
// ---------------------------------------------------------------------------
module step_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 270_000  // must be >= 1
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn,
  output logic pulse
);

  localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          state_reg;
  logic          pulse_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      state_reg <= 1'b0;
      pulse_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
      pulse_reg <= 1'b0;
      if (sync2_reg != state_reg) begin
        // Counter tracks how long the input has disagreed with the accepted
        // level; any agreement in between restarts the count.
        if (cnt_reg == CNT_LAST) begin
          state_reg <= sync2_reg;
          cnt_reg   <= '0;
          pulse_reg <= sync2_reg;  // only a new high level is a request
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign pulse = pulse_reg;

endmodule

// File: rtl/cpu_tick_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_tick_ctrl
//   Single-clock CPU step sequencer. Produces a one-cycle `tick` enable per
//   CPU step, qualified by the stepping mode and by the memory-busy stall,
//   and holds the core in reset for POR_CYCLES cycles after board reset.
//
// Ports:
//   clk         in  : board clock, the only clock
//   resetn      in  : asynchronous active-low board reset
//   mode        in  : 00 HALT, 01 STEP, 10 RUN, 11 FREE
//   div_load    in  : strobe, loads div_value into reload and divider
//   div_value   in  : new divider reload value
//   step_btn    in  : raw step push button, active-high
//   stall       in  : CPU/DMA busy; no tick issues while high
//   tick        out : one-cycle clock enable for CPU and register file
//   cpu_resetn  out : active-low core reset
//   pending     out : a request is waiting for stall to drop
//   tick_count  out : wrapping count of delivered ticks
//
// The reset reload value CLK_HZ/TICK_HZ-1 must fit in DIV_W bits and
// POR_CYCLES must be at least 1.
// ---------------------------------------------------------------------------
module cpu_tick_ctrl
  import tick_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 27_000_000,
  parameter int unsigned TICK_HZ         = 1,
  parameter int unsigned DIV_W           = 25,
  parameter int unsigned POR_CYCLES      = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 270_000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [1:0]       mode,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  input  logic             step_btn,
  input  logic             stall,
  output logic             tick,
  output logic             cpu_resetn,
  output logic             pending,
  output logic [CNT_W-1:0] tick_count
);

  localparam int unsigned      RELOAD_INIT = reload_calc(CLK_HZ, TICK_HZ);
  localparam logic [DIV_W-1:0] RELOAD_RST  = DIV_W'(RELOAD_INIT);
  localparam int unsigned      POR_W       = $clog2(POR_CYCLES + 1);
  localparam logic [POR_W-1:0] POR_LAST    = POR_W'(POR_CYCLES - 1);

  mode_e            mode_reg;
  logic [POR_W-1:0] por_cnt_reg;
  logic             cpu_resetn_reg;
  logic [DIV_W-1:0] reload_reg,  reload_next;
  logic [DIV_W-1:0] div_reg,     div_next;
  logic             pending_reg, pending_next;
  logic             tick_reg,    tick_next;
  logic [CNT_W-1:0] tick_count_reg, tick_count_next;

  logic             step_pulse;
  logic             mode_chg;
  logic             expire;
  logic             req;

  step_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_debounce (
    .clk   (clk),
    .resetn(resetn),
    .btn   (step_btn),
    .pulse (step_pulse)
  );

  // Power-on reset sequencer and mode register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      por_cnt_reg    <= '0;
      cpu_resetn_reg <= 1'b0;
      mode_reg       <= MODE_HALT;
    end else begin
      mode_reg <= mode_e'(mode);
      if (!cpu_resetn_reg) begin
        if (por_cnt_reg == POR_LAST) begin
          cpu_resetn_reg <= 1'b1;
        end else begin
          por_cnt_reg <= por_cnt_reg + 1'b1;
        end
      end
    end
  end

  always_comb begin
    mode_chg        = (mode_e'(mode) != mode_reg);
    expire          = (mode_reg == MODE_RUN) && (div_reg == '0);
    req             = expire || ((mode_reg == MODE_STEP) && step_pulse);

    reload_next     = reload_reg;
    div_next        = div_reg;
    pending_next    = pending_reg;
    tick_next       = 1'b0;
    tick_count_next = tick_count_reg;

    if (div_load) begin
      reload_next = div_value;
    end

    if (!cpu_resetn_reg || mode_chg) begin
      // Core in reset, or the mode register is about to change: restart the
      // period from the (possibly just loaded) reload value and forget any
      // request that belonged to the previous mode.
      div_next     = reload_next;
      pending_next = 1'b0;
    end else begin
      if (div_load) begin
        div_next = div_value;
      end else if ((mode_reg != MODE_RUN) || (div_reg == '0)) begin
        div_next = reload_reg;
      end else begin
        div_next = div_reg - 1'b1;
      end

      if (mode_reg == MODE_FREE) begin
        tick_next    = !stall;
        pending_next = 1'b0;
      end else if (pending_reg && !stall) begin
        // Delivering the held request; a new request landing in the same
        // cycle takes over the single pending slot instead of ticking twice.
        tick_next    = 1'b1;
        pending_next = req;
      end else if (req) begin
        if (stall) begin
          pending_next = 1'b1;  // already pending: the extra request is dropped
        end else begin
          tick_next = 1'b1;
        end
      end
    end

    if (tick_next) begin
      tick_count_next = tick_count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      reload_reg     <= RELOAD_RST;
      div_reg        <= RELOAD_RST;
      pending_reg    <= 1'b0;
      tick_reg       <= 1'b0;
      tick_count_reg <= '0;
    end else begin
      reload_reg     <= reload_next;
      div_reg        <= div_next;
      pending_reg    <= pending_next;
      tick_reg       <= tick_next;
      tick_count_reg <= tick_count_next;
    end
  end

  assign tick       = tick_reg;
  assign cpu_resetn = cpu_resetn_reg;
  assign pending    = pending_reg;
  assign tick_count = tick_count_reg;

endmodule
